// File: rtl/ea_sequencer_pkg.sv
// Shared constants for the effective-address sequencer: addressing-mode codes,
// one-hot state encodings and the small address helpers used by the datapath.
package ea_sequencer_pkg;

   localparam logic [2:0] MODE_IMP  = 3'd0;
   localparam logic [2:0] MODE_IMM  = 3'd1;
   localparam logic [2:0] MODE_ZP   = 3'd2;
   localparam logic [2:0] MODE_ZPX  = 3'd3;
   localparam logic [2:0] MODE_ABS  = 3'd4;
   localparam logic [2:0] MODE_ABSX = 3'd5;
   localparam logic [2:0] MODE_IND  = 3'd6;
   localparam logic [2:0] MODE_INDY = 3'd7;

   // State bit positions, so the one-hot vector can be tested bit by bit.
   localparam int S_IDLE   = 0;
   localparam int S_OP_LO  = 1;
   localparam int S_OP_HI  = 2;
   localparam int S_IDX    = 3;
   localparam int S_PTR_LO = 4;
   localparam int S_PTR_HI = 5;
   localparam int S_FIX    = 6;

   localparam logic [6:0] ST_IDLE   = 7'b000_0001;
   localparam logic [6:0] ST_OP_LO  = 7'b000_0010;
   localparam logic [6:0] ST_OP_HI  = 7'b000_0100;
   localparam logic [6:0] ST_IDX    = 7'b000_1000;
   localparam logic [6:0] ST_PTR_LO = 7'b001_0000;
   localparam logic [6:0] ST_PTR_HI = 7'b010_0000;
   localparam logic [6:0] ST_FIX    = 7'b100_0000;

   // 8-bit index add; bit 8 is the carry that signals a page cross.
   function automatic logic [8:0] idx_add(input logic [7:0] base, input logic [7:0] idx);
      return {1'b0, base} + {1'b0, idx};
   endfunction

   // Next byte address without carrying into the high byte.
   function automatic logic [15:0] page_inc(input logic [15:0] addr);
      return {addr[15:8], addr[7:0] + 8'd1};
   endfunction

endpackage

// File: rtl/ea_sequencer.sv
// Effective-address sequencer: walks the operand and pointer reads for one
// addressing mode and returns the effective address, updated PC and page-cross flag.
module ea_sequencer
   import ea_sequencer_pkg::*;
#(
   parameter logic        PAGE_PENALTY = 1'b1,
   parameter logic        IND_PAGE_BUG = 1'b1,
   parameter logic [15:0] ZP_BASE      = 16'h0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  mode,
   input  logic [15:0] pc_in,
   input  logic [7:0]  index,
   input  logic [7:0]  rd_data,
   output logic [15:0] mem_addr,
   output logic        mem_rd,
   output logic        busy,
   output logic        done,
   output logic [15:0] ea,
   output logic [15:0] pc_out,
   output logic        page_cross
);

   logic [6:0]  state;
   logic [2:0]  mode_r;
   logic [15:0] pc_r;
   logic [7:0]  idx_r;
   logic [7:0]  lo_r;
   logic [7:0]  hi_r;
   logic [8:0]  sum;
   logic [7:0]  zp_hi;

   assign zp_hi  = ZP_BASE[15:8];
   // lo_r holds the operand low byte for ABSX/ZPX and the pointer low byte for INDY.
   assign sum    = idx_add(lo_r, idx_r);
   assign busy   = ~state[S_IDLE];
   assign mem_rd = ~state[S_IDLE];

   always_ff @(posedge clk or posedge reset) begin
      // NOTE: every register here uses non-blocking assignment so all next-state
      // values are computed from the same pre-edge snapshot.
      if (reset) begin
         state      <= ST_IDLE;
         mode_r     <= '0;
         pc_r       <= '0;
         idx_r      <= '0;
         lo_r       <= '0;
         hi_r       <= '0;
         mem_addr   <= '0;
         done       <= 1'b0;
         ea         <= '0;
         pc_out     <= '0;
         page_cross <= 1'b0;
      end else begin
         done <= 1'b0;
         case (1'b1)
            state[S_IDLE]: begin
               if (start) begin
                  mode_r <= mode;
                  pc_r   <= pc_in;
                  idx_r  <= index;
                  case (mode)
                     MODE_IMP: begin
                        done       <= 1'b1;
                        ea         <= '0;
                        pc_out     <= pc_in;
                        page_cross <= 1'b0;
                     end
                     MODE_IMM: begin
                        done       <= 1'b1;
                        ea         <= pc_in;
                        pc_out     <= pc_in + 16'd1;
                        page_cross <= 1'b0;
                     end
                     default: begin
                        state    <= ST_OP_LO;
                        mem_addr <= pc_in;
                     end
                  endcase
               end
            end

            state[S_OP_LO]: begin
               lo_r <= rd_data;
               case (mode_r)
                  MODE_ZP: begin
                     state      <= ST_IDLE;
                     done       <= 1'b1;
                     ea         <= {zp_hi, rd_data};
                     pc_out     <= pc_r + 16'd1;
                     page_cross <= 1'b0;
                  end
                  MODE_ZPX: begin
                     state    <= ST_IDX;
                     mem_addr <= {zp_hi, rd_data};
                  end
                  MODE_INDY: begin
                     state    <= ST_PTR_LO;
                     mem_addr <= {zp_hi, rd_data};
                  end
                  default: begin
                     state    <= ST_OP_HI;
                     mem_addr <= pc_r + 16'd1;
                  end
               endcase
            end

            state[S_OP_HI]: begin
               hi_r <= rd_data;
               case (mode_r)
                  MODE_ABS: begin
                     state      <= ST_IDLE;
                     done       <= 1'b1;
                     ea         <= {rd_data, lo_r};
                     pc_out     <= pc_r + 16'd2;
                     page_cross <= 1'b0;
                  end
                  MODE_ABSX: begin
                     if (sum[8] && PAGE_PENALTY) begin
                        state    <= ST_FIX;
                        mem_addr <= {rd_data, sum[7:0]};
                     end else begin
                        state      <= ST_IDLE;
                        done       <= 1'b1;
                        ea         <= {rd_data, lo_r} + {8'h00, idx_r};
                        pc_out     <= pc_r + 16'd2;
                        page_cross <= sum[8];
                     end
                  end
                  default: begin
                     state    <= ST_PTR_LO;
                     mem_addr <= {rd_data, lo_r};
                  end
               endcase
            end

            state[S_IDX]: begin
               // Zero-page indexing wraps inside the page, so no page cross.
               state      <= ST_IDLE;
               done       <= 1'b1;
               ea         <= {zp_hi, sum[7:0]};
               pc_out     <= pc_r + 16'd1;
               page_cross <= 1'b0;
            end

            state[S_PTR_LO]: begin
               lo_r  <= rd_data;
               state <= ST_PTR_HI;
               // INDY pointers always wrap in the zero page; IND wraps only on NMOS.
               if (IND_PAGE_BUG || mode_r == MODE_INDY) mem_addr <= page_inc(mem_addr);
               else                                     mem_addr <= mem_addr + 16'd1;
            end

            state[S_PTR_HI]: begin
               hi_r <= rd_data;
               if (mode_r == MODE_INDY && sum[8] && PAGE_PENALTY) begin
                  state    <= ST_FIX;
                  mem_addr <= {rd_data, sum[7:0]};
               end else if (mode_r == MODE_INDY) begin
                  state      <= ST_IDLE;
                  done       <= 1'b1;
                  ea         <= {rd_data, lo_r} + {8'h00, idx_r};
                  pc_out     <= pc_r + 16'd1;
                  page_cross <= sum[8];
               end else begin
                  state      <= ST_IDLE;
                  done       <= 1'b1;
                  ea         <= {rd_data, lo_r};
                  pc_out     <= pc_r + 16'd2;
                  page_cross <= 1'b0;
               end
            end

            state[S_FIX]: begin
               state      <= ST_IDLE;
               done       <= 1'b1;
               ea         <= {hi_r, lo_r} + {8'h00, idx_r};
               pc_out     <= (mode_r == MODE_INDY) ? pc_r + 16'd1 : pc_r + 16'd2;
               page_cross <= 1'b1;
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ea_sequencer.sv
// Scoreboard bench for ea_sequencer: two instances (NMOS/penalty defaults and a
// 65C02-style, no-penalty, relocated zero page) run the same directed vectors.
module tb_ea_sequencer;

   typedef struct packed {
      logic [15:0]      ea;
      logic [15:0]      pco;
      logic             pc;
      logic [3:0]       lat;
      logic [2:0]       nrd;
      logic [4:0][15:0] addrs;
   } exp_t;

   localparam logic [2:0] IMP = 3'd0, IMM = 3'd1, ZP = 3'd2, ZPX = 3'd3,
                          ABS = 3'd4, ABSX = 3'd5, IND = 3'd6, INDY = 3'd7;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  mode;
   logic [15:0] pc_in;
   logic [7:0]  index;

   logic [7:0]  rd_data_m, rd_data_a;
   logic [15:0] mem_addr_m, mem_addr_a, ea_m, ea_a, pc_out_m, pc_out_a;
   logic        mem_rd_m, mem_rd_a, busy_m, busy_a, done_m, done_a, page_cross_m, page_cross_a;

   logic [7:0] mem [0:65535];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   exp_t q_m[$];
   exp_t q_a[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign rd_data_m = mem[mem_addr_m];
   assign rd_data_a = mem[mem_addr_a];

   ea_sequencer dut_m (
      .clk(clk), .reset(reset), .start(start), .mode(mode), .pc_in(pc_in), .index(index),
      .rd_data(rd_data_m), .mem_addr(mem_addr_m), .mem_rd(mem_rd_m), .busy(busy_m),
      .done(done_m), .ea(ea_m), .pc_out(pc_out_m), .page_cross(page_cross_m)
   );

   ea_sequencer #(.PAGE_PENALTY(1'b0), .IND_PAGE_BUG(1'b0), .ZP_BASE(16'h0300)) dut_a (
      .clk(clk), .reset(reset), .start(start), .mode(mode), .pc_in(pc_in), .index(index),
      .rd_data(rd_data_a), .mem_addr(mem_addr_a), .mem_rd(mem_rd_a), .busy(busy_a),
      .done(done_a), .ea(ea_a), .pc_out(pc_out_a), .page_cross(page_cross_a)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic exp_t mk(input logic [15:0] ea, input logic [15:0] pco, input logic pc,
                               input int lat, input int nrd,
                               input logic [15:0] a0 = 16'h0, input logic [15:0] a1 = 16'h0,
                               input logic [15:0] a2 = 16'h0, input logic [15:0] a3 = 16'h0,
                               input logic [15:0] a4 = 16'h0);
      exp_t e;
      e.ea       = ea;
      e.pco      = pco;
      e.pc       = pc;
      e.lat      = 4'(lat);
      e.nrd      = 3'(nrd);
      e.addrs[0] = a0;
      e.addrs[1] = a1;
      e.addrs[2] = a2;
      e.addrs[3] = a3;
      e.addrs[4] = a4;
      return e;
   endfunction

   task automatic score(input string tag, input exp_t e, input logic [15:0] a_ea,
                        input logic [15:0] a_pco, input logic a_pc, input int lat,
                        input int nrd, input logic [4:0][15:0] log);
      check($sformatf("%s ea", tag), {16'h0, a_ea}, {16'h0, e.ea});
      check($sformatf("%s pc_out", tag), {16'h0, a_pco}, {16'h0, e.pco});
      check($sformatf("%s page_cross", tag), {31'h0, a_pc}, {31'h0, e.pc});
      check($sformatf("%s latency", tag), lat, {28'h0, e.lat});
      check($sformatf("%s read count", tag), nrd, {29'h0, e.nrd});
      for (int i = 0; i < 5; i++)
         if (i < int'(e.nrd))
            check($sformatf("%s read addr %0d", tag, i), {16'h0, log[i]}, {16'h0, e.addrs[i]});
   endtask

   // Monitors: log reads since the accepted start, score each done against the queue.
   logic [4:0][15:0] log_m, log_a;
   int   nlog_m, nlog_a, t0_m, t0_a;
   exp_t e_m, e_a;

   always @(negedge clk) begin
      if (reset) begin
         nlog_m = 0;
         t0_m   = cyc;
      end else begin
         if (mem_rd_m) begin
            if (nlog_m < 5) log_m[nlog_m] = mem_addr_m;
            nlog_m++;
         end
         if (done_m) begin
            if (q_m.size() == 0) begin
               total++; bad++;
               $display("FAIL main unexpected done: ea=%0h", ea_m);
            end else begin
               e_m = q_m.pop_front();
               score("main", e_m, ea_m, pc_out_m, page_cross_m, cyc - t0_m, nlog_m, log_m);
            end
         end
         if (start && !busy_m) begin
            t0_m   = cyc;
            nlog_m = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (reset) begin
         nlog_a = 0;
         t0_a   = cyc;
      end else begin
         if (mem_rd_a) begin
            if (nlog_a < 5) log_a[nlog_a] = mem_addr_a;
            nlog_a++;
         end
         if (done_a) begin
            if (q_a.size() == 0) begin
               total++; bad++;
               $display("FAIL alt unexpected done: ea=%0h", ea_a);
            end else begin
               e_a = q_a.pop_front();
               score("alt", e_a, ea_a, pc_out_a, page_cross_a, cyc - t0_a, nlog_a, log_a);
            end
         end
         if (start && !busy_a) begin
            t0_a   = cyc;
            nlog_a = 0;
         end
      end
   end

   // Called just after a rising edge; start is held for exactly one cycle.
   task automatic issue(input logic [2:0] m, input logic [15:0] p, input logic [7:0] x);
      start = 1'b1; mode = m; pc_in = p; index = x;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (q_m.size() == 0 && q_a.size() == 0) break;
      end
      if (q_m.size() != 0 || q_a.size() != 0) begin
         total++; bad++;
         $display("FAIL timeout: pending main=%0d alt=%0d", q_m.size(), q_a.size());
         q_m.delete();
         q_a.delete();
      end
      @(posedge clk); #1;
   endtask

   task automatic run(input logic [2:0] m, input logic [15:0] p, input logic [7:0] x,
                      input exp_t em, input exp_t ea_exp);
      q_m.push_back(em);
      q_a.push_back(ea_exp);
      issue(m, p, x);
      wait_idle();
   endtask

   task automatic check_zero(input string tag);
      check({tag, " main outs"}, {ea_m, pc_out_m}, 32'h0);
      check({tag, " main ctl"}, {mem_addr_m, 12'h0, mem_rd_m, busy_m, done_m, page_cross_m}, 32'h0);
      check({tag, " alt outs"}, {ea_a, pc_out_a}, 32'h0);
      check({tag, " alt ctl"}, {mem_addr_a, 12'h0, mem_rd_a, busy_a, done_a, page_cross_a}, 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
      mem[16'h0200] = 8'h34; mem[16'h0201] = 8'h12;
      mem[16'h0210] = 8'hF0; mem[16'h0211] = 8'h12;
      mem[16'h0220] = 8'h10; mem[16'h0221] = 8'h40;
      mem[16'h0230] = 8'hF0;
      mem[16'h0240] = 8'h45;
      mem[16'h0250] = 8'hFF; mem[16'h0251] = 8'h10;
      mem[16'h10FF] = 8'h00; mem[16'h1000] = 8'h80; mem[16'h1100] = 8'h90;
      mem[16'h0260] = 8'hFF;
      mem[16'h00FF] = 8'hF0; mem[16'h0000] = 8'h20;
      mem[16'h03FF] = 8'hF8; mem[16'h0300] = 8'h70;
      mem[16'hFFFF] = 8'hAB;
      mem[16'h0270] = 8'h80;
      mem[16'h0080] = 8'h10; mem[16'h0081] = 8'h55;
      mem[16'h0380] = 8'hFE; mem[16'h0381] = 8'h01;

      reset = 1'b1; start = 1'b0; mode = '0; pc_in = '0; index = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check_zero("reset");
      @(posedge clk); #1;

      run(IMP,  16'h1234, 8'h00, mk(16'h0000, 16'h1234, 0, 1, 0), mk(16'h0000, 16'h1234, 0, 1, 0));
      run(IMM,  16'hFFFF, 8'h00, mk(16'hFFFF, 16'h0000, 0, 1, 0), mk(16'hFFFF, 16'h0000, 0, 1, 0));
      run(ABS,  16'h0200, 8'h00, mk(16'h1234, 16'h0202, 0, 3, 2, 16'h0200, 16'h0201),
                                 mk(16'h1234, 16'h0202, 0, 3, 2, 16'h0200, 16'h0201));
      run(ABSX, 16'h0210, 8'h20, mk(16'h1310, 16'h0212, 1, 4, 3, 16'h0210, 16'h0211, 16'h1210),
                                 mk(16'h1310, 16'h0212, 1, 3, 2, 16'h0210, 16'h0211));
      run(ABSX, 16'h0220, 8'h05, mk(16'h4015, 16'h0222, 0, 3, 2, 16'h0220, 16'h0221),
                                 mk(16'h4015, 16'h0222, 0, 3, 2, 16'h0220, 16'h0221));
      run(ZPX,  16'h0230, 8'h20, mk(16'h0010, 16'h0231, 0, 3, 2, 16'h0230, 16'h00F0),
                                 mk(16'h0310, 16'h0231, 0, 3, 2, 16'h0230, 16'h03F0));
      run(ZP,   16'h0240, 8'h00, mk(16'h0045, 16'h0241, 0, 2, 1, 16'h0240),
                                 mk(16'h0345, 16'h0241, 0, 2, 1, 16'h0240));
      run(IND,  16'h0250, 8'h00, mk(16'h8000, 16'h0252, 0, 5, 4, 16'h0250, 16'h0251, 16'h10FF, 16'h1000),
                                 mk(16'h9000, 16'h0252, 0, 5, 4, 16'h0250, 16'h0251, 16'h10FF, 16'h1100));
      run(INDY, 16'h0260, 8'h10, mk(16'h2100, 16'h0261, 1, 5, 4, 16'h0260, 16'h00FF, 16'h0000, 16'h2000),
                                 mk(16'h7108, 16'h0261, 1, 4, 3, 16'h0260, 16'h03FF, 16'h0300));
      run(ABS,  16'hFFFF, 8'h00, mk(16'h20AB, 16'h0001, 0, 3, 2, 16'hFFFF, 16'h0000),
                                 mk(16'h20AB, 16'h0001, 0, 3, 2, 16'hFFFF, 16'h0000));
      run(INDY, 16'h0270, 8'h01, mk(16'h5511, 16'h0271, 0, 4, 3, 16'h0270, 16'h0080, 16'h0081),
                                 mk(16'h01FF, 16'h0271, 0, 4, 3, 16'h0270, 16'h0380, 16'h0381));

      // A second start while busy must be ignored.
      q_m.push_back(mk(16'h1234, 16'h0202, 0, 3, 2, 16'h0200, 16'h0201));
      q_a.push_back(mk(16'h1234, 16'h0202, 0, 3, 2, 16'h0200, 16'h0201));
      start = 1'b1; mode = ABS; pc_in = 16'h0200; index = 8'h00;
      @(posedge clk); #1;
      mode = IMP; pc_in = 16'h5555;
      @(posedge clk); #1;
      start = 1'b0;
      wait_idle();

      // Back-to-back: ABS start lands in the done cycle of IMM.
      q_m.push_back(mk(16'h0300, 16'h0301, 0, 1, 0));
      q_a.push_back(mk(16'h0300, 16'h0301, 0, 1, 0));
      q_m.push_back(mk(16'h1234, 16'h0202, 0, 3, 2, 16'h0200, 16'h0201));
      q_a.push_back(mk(16'h1234, 16'h0202, 0, 3, 2, 16'h0200, 16'h0201));
      start = 1'b1; mode = IMM; pc_in = 16'h0300; index = 8'h00;
      @(posedge clk); #1;
      mode = ABS; pc_in = 16'h0200;
      @(posedge clk); #1;
      start = 1'b0;
      wait_idle();

      // Reset in cycle 2 of ABS aborts with no done and clears held results.
      start = 1'b1; mode = ABS; pc_in = 16'h0200; index = 8'h00;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      check_zero("abort");
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (6) @(posedge clk);
      @(negedge clk);
      check_zero("after abort");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
